// File: rtl/touch_gesture_ctrl_if.sv
// Touch-key gesture bundle: raw pad level in, read enable / mode / gesture strobes out.
// Strobes are 1-cycle fire-and-forget events with no ready/backpressure; rd_en and mode are levels.
interface touch_gesture_ctrl_if;
  logic       touch_key;
  logic       rd_en;
  logic [1:0] mode;
  logic       tap_pulse;
  logic       dtap_pulse;
  logic       long_pulse;
  logic       busy;
  logic [2:0] dbg_state;

  modport master (
    input  touch_key,
    output rd_en, mode, tap_pulse, dtap_pulse, long_pulse, busy, dbg_state
  );

  modport slave (
    output touch_key,
    input  rd_en, mode, tap_pulse, dtap_pulse, long_pulse, busy, dbg_state
  );
endinterface

// File: rtl/touch_gesture_ctrl.sv
// Debounces the touch pad and classifies presses as tap / double tap / long press,
// driving the read enable toggle and the 2-bit mode stepper.
module touch_gesture_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned DTAP_CYC     = 15_000_000
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  touch_gesture_ctrl_if.master bus
);
  localparam int unsigned DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned GMAX = (LONG_CYC > DTAP_CYC) ? LONG_CYC : DTAP_CYC;
  localparam int unsigned GW   = (GMAX > 1) ? $clog2(GMAX) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [GW-1:0] LONG_LAST = GW'(LONG_CYC - 1);
  localparam logic [GW-1:0] DTAP_LAST = GW'(DTAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS1   = 3'd1,
    S_GAP      = 3'd2,
    S_PRESS2   = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  logic          r_sync1;
  logic          r_key_s;
  logic          r_key_db;
  logic          r_key_db_d;
  logic [DW-1:0] r_dcnt;
  logic [GW-1:0] r_gcnt;
  state_t        r_state;
  state_t        w_state_next;
  logic          w_db_rise;
  logic          w_db_fall;
  logic          w_tap_set;
  logic          w_dtap_set;
  logic          w_long_set;
  logic          w_busy;
  logic          r_tap;
  logic          r_dtap;
  logic          r_long;
  logic          r_rd_en;
  logic [1:0]    r_mode;

  // Debounced level only follows key_s after DEBOUNCE_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_key_s    <= 1'b0;
      r_key_db   <= 1'b0;
      r_key_db_d <= 1'b0;
      r_dcnt     <= '0;
    end else begin
      r_sync1    <= bus.touch_key;
      r_key_s    <= r_sync1;
      r_key_db_d <= r_key_db;
      if (r_key_s != r_key_db) begin
        if (r_dcnt == DCNT_LAST) begin
          r_key_db <= r_key_s;
          r_dcnt   <= '0;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  assign w_db_rise = r_key_db & ~r_key_db_d;
  assign w_db_fall = ~r_key_db & r_key_db_d;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_gcnt <= '0;
    end else if (w_state_next != r_state) begin
      r_gcnt <= '0;
    end else if (r_gcnt != '1) begin
      r_gcnt <= r_gcnt + GW'(1);
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Edges are tested before timeouts so an edge landing on the timeout cycle wins.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_db_rise) w_state_next = S_PRESS1;
      S_PRESS1: begin
        if (w_db_fall)                                 w_state_next = S_GAP;
        else if (r_gcnt == LONG_LAST && r_key_db)      w_state_next = S_WAIT_REL;
      end
      S_GAP: begin
        if (w_db_rise)                                 w_state_next = S_PRESS2;
        else if (r_gcnt == DTAP_LAST)                  w_state_next = S_IDLE;
      end
      S_PRESS2: begin
        if (w_db_fall)                                 w_state_next = S_IDLE;
        else if (r_gcnt == LONG_LAST)                  w_state_next = S_WAIT_REL;
      end
      S_WAIT_REL: if (w_db_fall) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tap_set  = 1'b0;
    w_dtap_set = 1'b0;
    w_long_set = 1'b0;
    w_busy     = (r_state != S_IDLE);
    case (r_state)
      S_PRESS1: w_long_set = !w_db_fall && r_gcnt == LONG_LAST && r_key_db;
      S_GAP:    w_tap_set  = !w_db_rise && r_gcnt == DTAP_LAST;
      S_PRESS2: begin
        w_dtap_set = w_db_fall;
        w_long_set = !w_db_fall && r_gcnt == LONG_LAST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_tap   <= 1'b0;
      r_dtap  <= 1'b0;
      r_long  <= 1'b0;
      r_rd_en <= 1'b0;
      r_mode  <= 2'd0;
    end else begin
      r_tap  <= w_tap_set;
      r_dtap <= w_dtap_set;
      r_long <= w_long_set;
      if (w_long_set) begin
        r_rd_en <= 1'b0;
        r_mode  <= 2'd0;
      end else if (w_dtap_set) begin
        r_mode <= r_mode + 2'd1;
      end else if (w_tap_set) begin
        r_rd_en <= ~r_rd_en;
      end
    end
  end

  assign bus.rd_en      = r_rd_en;
  assign bus.mode       = r_mode;
  assign bus.tap_pulse  = r_tap;
  assign bus.dtap_pulse = r_dtap;
  assign bus.long_pulse = r_long;
  assign bus.busy       = w_busy;
  assign bus.dbg_state  = r_state;
endmodule
